// File: rtl/keccak_slicer.sv
// Snapshot register that hands a wide Keccak state out as narrow words, either by index (1-cycle read) or as a
// valid/ready stream with no bubbles; define KECCAK_SLICER_BSWAP_EN to byte-reverse every output word.
module keccak_slicer #(
  parameter  int IN_W  = 512,
  parameter  int OUT_W = 32,
  localparam int WORDS = IN_W / OUT_W,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  in_data,
  input  logic             rd_en,
  input  logic [5:0]       rd_idx,
  input  logic             start,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IN_W-1:0]  snap_q, snap_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  // Only the low index bits select a word; the rest of the instruction field is don't-care.
  logic unused_idx_bits;
  assign unused_idx_bits = ^rd_idx[5:IDX_W];

  function automatic logic [OUT_W-1:0] word_of(input logic [IN_W-1:0] snap, input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] w;
    logic [OUT_W-1:0] r;
    w = snap[idx*OUT_W +: OUT_W];
`ifdef KECCAK_SLICER_BSWAP_EN
    for (int b = 0; b < OUT_W / 8; b++) begin
      r[b*8 +: 8] = w[OUT_W-8-b*8 +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    snap_d  = snap_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;

    if (load) begin
      snap_d = in_data;
    end

    // All read data comes from snap_q, so a read coinciding with load sees the old snapshot.
    case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
        if (start && !load) begin
          state_d = ST_FETCH;
          ptr_d   = '0;
        end else if (rd_en && !start) begin
          dout_d = word_of(snap_q, rd_idx[IDX_W-1:0]);
          vld_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        dout_d  = word_of(snap_q, ptr_q);
        vld_d   = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (vld_q && dout_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d  = ptr_q + 1'b1;
            dout_d = word_of(snap_q, ptr_q + 1'b1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase

    // A new snapshot invalidates any stream in flight.
    if (load && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      done_d  = 1'b0;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_keccak_slicer.sv
// Directed bench for keccak_slicer at default widths: random reads, streaming, stalls, aborts, reset.
module tb_keccak_slicer;

  logic         clk = 1'b0;
  logic         rst, load, rd_en, start, dout_ready;
  logic [511:0] in_data;
  logic [5:0]   rd_idx;
  logic [31:0]  dout;
  logic         dout_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  keccak_slicer dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .in_data    (in_data),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .start      (start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output form of a snapshot word.
  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef KECCAK_SLICER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_snap(input logic [511:0] d);
    in_data = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Leaves the bench sampling the cycle in which word 0 is first valid.
  task automatic start_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("fetch_no_valid", {31'b0, dout_valid}, 32'd0);
    tick();
  endtask

  logic [511:0] pat;
  logic         seen_done;
  int           n_words;

  initial begin
    rst = 1'b1; load = 1'b0; rd_en = 1'b0; start = 1'b0; dout_ready = 1'b0;
    in_data = '0; rd_idx = '0;
    for (int k = 0; k < 16; k++) pat[k*32 +: 32] = 32'h1000_0000 + k;

    tick(); tick();
    check("rst_dout", dout, 32'h0);
    check("rst_valid", {31'b0, dout_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    load_snap(pat);

    // Random read, index 5, then aliased index 21.
    rd_en = 1'b1; rd_idx = 6'd5;
    tick();
    rd_en = 1'b0;
    check("rd5_dout", dout, ew(32'h1000_0005));
    check("rd5_valid", {31'b0, dout_valid}, 32'd1);
    tick();
    check("rd5_valid_pulse", {31'b0, dout_valid}, 32'd0);
    check("rd5_hold", dout, ew(32'h1000_0005));
    rd_en = 1'b1; rd_idx = 6'd21;
    tick();
    rd_en = 1'b0;
    check("rd21_dout", dout, ew(32'h1000_0005));
    tick();

    // Full-rate stream.
    dout_ready = 1'b1;
    start_stream();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("str_w%0d", k), dout, ew(32'h1000_0000 + k));
      check($sformatf("str_v%0d", k), {31'b0, dout_valid}, 32'd1);
      check($sformatf("str_nd%0d", k), {31'b0, done}, 32'd0);
      tick();
    end
    check("str_done", {31'b0, done}, 32'd1);
    check("str_busy_end", {31'b0, busy}, 32'd0);
    check("str_valid_end", {31'b0, dout_valid}, 32'd0);
    tick();
    check("str_done_pulse", {31'b0, done}, 32'd0);

    // Stream with a 3-cycle stall on word 3.
    start_stream();
    n_words = 0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("stall_w%0d", k), dout, ew(32'h1000_0000 + k));
      if (k == 3) begin
        dout_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_hold", dout, ew(32'h1000_0003));
          check("stall_valid", {31'b0, dout_valid}, 32'd1);
        end
        dout_ready = 1'b1;
      end
      if (dout_valid && dout_ready) n_words++;
      tick();
    end
    check("stall_count", n_words, 32'd16);
    check("stall_done", {31'b0, done}, 32'd1);
    tick();

    // Load of all-ones while word 7 is presented aborts the stream.
    start_stream();
    repeat (7) tick();
    check("abort_w7", dout, ew(32'h1000_0007));
    load_snap({512{1'b1}});
    check("abort_valid", {31'b0, dout_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_no_done", {31'b0, done}, 32'd0);
    tick();
    check("abort_no_done2", {31'b0, done}, 32'd0);
    rd_en = 1'b1; rd_idx = 6'd7;
    tick();
    rd_en = 1'b0;
    check("abort_rd7", dout, 32'hFFFF_FFFF);

    // Read in the same cycle as load returns the old contents.
    rd_en = 1'b1; rd_idx = 6'd2; in_data = pat; load = 1'b1;
    tick();
    rd_en = 1'b0; load = 1'b0;
    check("rbw_old", dout, 32'hFFFF_FFFF);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rbw_new", dout, ew(32'h1000_0002));
    tick();

    // Start and rd_en while busy are ignored.
    start_stream();
    tick(); tick();
    check("busy_w2", dout, ew(32'h1000_0002));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_ignored", dout, ew(32'h1000_0003));
    rd_en = 1'b1; rd_idx = 6'd9;
    tick();
    rd_en = 1'b0;
    check("rd_busy_ignored", dout, ew(32'h1000_0004));
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("busy_run_done", {31'b0, seen_done}, 32'd1);
    tick();

    // Reset mid-stream.
    start_stream();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("mrst_dout", dout, 32'h0);
    check("mrst_valid", {31'b0, dout_valid}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // Byte order of a distinctive word.
    pat[31:0] = 32'h1122_3344;
    load_snap(pat);
    rd_en = 1'b1; rd_idx = 6'd0;
    tick();
    rd_en = 1'b0;
`ifdef KECCAK_SLICER_BSWAP_EN
    check("bswap_word", dout, 32'h4433_2211);
`else
    check("plain_word", dout, 32'h1122_3344);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_slicer.md
# keccak_slicer

Registered, parametrised wide-to-narrow word slicer between the Keccak core and `keccak_ctrl`. Captures an `IN_W`-bit state/digest snapshot and delivers it as `OUT_W`-bit words, either by random-access index or as an auto-incrementing stream with a valid/ready handshake. The snapshot register decouples the core's output from the custom-instruction read path, so the core can resume while words are drained.

## Interface
- `IN_W`, default 512: snapshot width; must be a multiple of `OUT_W`.
- `OUT_W`, default 32: output word width.
- `WORDS`, derived, `IN_W/OUT_W`: a power of two (16 at defaults).
- `IDX_W`, derived, `$clog2(WORDS)`: 4 at defaults.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: capture `in_data` into the snapshot.
- `in_data` in `IN_W`: wide input from the core.
- `rd_en` in 1: random-access read request.
- `rd_idx` in 6: word index (the `cust5_limm` field); only `[IDX_W-1:0]` is used.
- `start` in 1: begin streaming from word 0.
- `dout` out `OUT_W`: output word (registered).
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: stream-mode consumer acceptance; ignored for random reads.
- `busy` out 1: FSM is not IDLE.
- `done` out 1: one-cycle pulse after the last stream word is accepted.

## Operation
- Word `k` = snapshot`[k*OUT_W +: OUT_W]`; word 0 is the LSBs.
- Priority, highest first: `rst` > `load` > `start` > `rd_en`.
- `load`: snapshot <= `in_data`.
  - In FETCH/STREAM: aborts the stream. Next state IDLE, `dout_valid` drops, no `done`.
- FSM states: IDLE, FETCH, STREAM.
  - IDLE + `start` -> FETCH; pointer <= 0.
  - FETCH -> STREAM unconditionally; `dout` <= word 0, `dout_valid` <= 1.
  - STREAM with `dout_valid && dout_ready`:
    - If pointer != WORDS-1: pointer++, `dout` <= next word, valid stays 1 (no bubble).
    - If pointer == WORDS-1: -> IDLE, valid <= 0, `done` <= 1 for one cycle.
  - STREAM without `dout_ready`: `dout` and valid are held stable.
- Random read (IDLE only): `rd_en` -> `dout` <= word `rd_idx[IDX_W-1:0]`, `dout_valid` pulses 1 for one cycle. Upper index bits are ignored, so index 17 reads word 1 at defaults.
- `rd_en` or `start` while `busy` is ignored; there is no queuing.
- `dout` holds its last value whenever `dout_valid` is 0.
- Read-before-write: `rd_en` in the same cycle as `load` returns the old snapshot contents. `load` has priority only over FSM state, not over the read data source.
- `start` in the same cycle as `load`: `load` wins, `start` is dropped.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, snapshot=0, pointer=0, state=IDLE.
- `load` at cycle t: new snapshot is readable from t+1.
- Random read: `rd_en` at t -> `dout_valid` at t+1 (1-cycle latency).
- Stream: `start` at t -> `busy` from t+1, first word valid at t+2.
  - With `dout_ready` held high: the last word is at t+1+WORDS, `done` at t+2+WORDS, `busy` low at t+2+WORDS.
- `rst` mid-stream: all outputs return to reset values at the next edge.

## Configuration
- `KECCAK_SLICER_BSWAP_EN` defined: every `dout` word is byte-reversed (byte 0 to MSB) for big-endian software consumers. `OUT_W` must be a multiple of 8.
- Not defined: words are passed unmodified.

## Test plan
- Defaults; snapshot word k = 32'h1000_0000+k; `rd_en` with `rd_idx`=5 -> next cycle `dout`=32'h1000_0005, `dout_valid`=1 for exactly one cycle. `rd_idx`=6'd21 -> 32'h1000_0005.
- Same snapshot; `start` with `dout_ready`=1 -> `dout` 32'h1000_0000..32'h1000_000F on 16 consecutive cycles starting 2 cycles after `start`, then `done`=1 for one cycle and `busy`=0.
- Stream with `dout_ready` low for 3 cycles on word 3 -> `dout`=32'h1000_0003 held stable; the stream then resumes with word 4, and all 16 words are delivered exactly once.
- `load` of all-ones during word 7 of a stream -> stream aborts: `dout_valid`=0, no `done`. A following `rd_en` with idx 7 returns 32'hFFFF_FFFF.
- `rd_en` and `load` in the same cycle -> the old word is returned; `start` while `busy` is ignored; `rst` mid-stream -> all outputs 0 next cycle.
- With `KECCAK_SLICER_BSWAP_EN`: word 32'h1122_3344 read -> `dout`=32'h4433_2211.
